// File: rtl/spi_responder.sv
// spi_responder - SPI mode-0 target that lets an external host exchange bytes
// with the CPU through one memory-mapped I/O word.
//
// All pins are resynchronised into the clk domain; the block runs only on clk.
// The host SCK must be at most clk/8.
//
// Optional feature macro: SPI_RESPONDER_FRAMECNT_EN
//   defined   -> out[12:8] counts complete bytes in the current or most recent
//                CSX-low frame (saturating at 31, zeroed on CSX fall)
//   undefined -> out[12:8] is constant 0 and no counter is built
//
// Ports:
//   clk     in   internal clock
//   resetx  in   synchronous active-low reset
//   in      in   CPU write data: [7:0] TX byte, [8] clear RX, [9] queue TX
//   load    in   memory-map write strobe
//   out     out  {rx_empty, tx_pending, overrun, frame_cnt/0, last RX byte}
//   SCK     in   serial clock from host
//   CSX     in   chip select, active low
//   SDI     in   host->target data (MOSI)
//   SDO     out  target->host data (MISO)
//   SDO_EN  out  1 = drive the SDO pad, 0 = tri-state at top level

module spi_responder #(
  parameter logic [7:0] FILL        = 8'hFF,
  parameter int         SYNC_STAGES = 2      // must be at least 2
) (
  input  logic        clk,
  input  logic        resetx,
  input  logic [15:0] in,
  input  logic        load,
  output logic [15:0] out,
  input  logic        SCK,
  input  logic        CSX,
  input  logic        SDI,
  output logic        SDO,
  output logic        SDO_EN
);

  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic sck_s, cs_s, sdi_s;
  logic sck_d, cs_d;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic       rx_done;
  logic       sdo_int;
  logic       sdo_en_int;

  logic [7:0] hold;
  logic       pending;
  logic       reload;
  logic [7:0] reload_byte;

  logic       rx_empty;
  logic       overrun;
  logic [7:0] rx_data;
  logic [4:0] frame_field;

  logic       queue_wr;
  logic       clear_wr;
  logic       unused_in;

  assign queue_wr  = load & in[9];
  assign clear_wr  = load & in[8];
  assign unused_in = ^in[15:10];

  // Pin synchronisers are deliberately not reset: they keep sampling the pins
  // during reset so the WAIT state sees the true CSX level afterwards.
  always_ff @(posedge clk) begin
    sck_sync <= {sck_sync[SYNC_STAGES-2:0], SCK};
    cs_sync  <= {cs_sync[SYNC_STAGES-2:0], CSX};
    sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], SDI};
    sck_d    <= sck_sync[SYNC_STAGES-1];
    cs_d     <= cs_sync[SYNC_STAGES-1];
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;

  // A TX reload happens at frame start and at every byte boundary (the SCK
  // fall after the 8th rise). It takes the queued byte if there is one.
  assign reload_byte = pending ? hold : FILL;
  assign reload = ((state == ST_IDLE) && cs_fall) ||
                  ((state == ST_SHIFT) && !cs_rise && sck_fall && (bit_cnt == 3'd0));

  // Frame state machine: WAIT holds off until CSX is seen high (both the
  // synchronised level and its delayed copy) so that a reset released in
  // the middle of a host frame never joins that frame part-way through.
  always_ff @(posedge clk) begin
    if (!resetx) begin
      state      <= ST_WAIT;
      bit_cnt    <= 3'd0;
      tx_shift   <= FILL;
      rx_shift   <= 8'h00;
      rx_done    <= 1'b0;
      sdo_int    <= 1'b1;
      sdo_en_int <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        ST_WAIT: begin
          sdo_en_int <= 1'b0;
          if (cs_s && cs_d) state <= ST_IDLE;
        end
        ST_IDLE: begin
          sdo_en_int <= 1'b0;
          if (cs_fall) begin
            tx_shift   <= reload_byte;
            sdo_int    <= reload_byte[7];
            sdo_en_int <= 1'b1;
            bit_cnt    <= 3'd0;
            state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            state      <= ST_IDLE;
            sdo_en_int <= 1'b0;
            bit_cnt    <= 3'd0;
          end else begin
            if (sck_rise) begin
              rx_shift <= {rx_shift[6:0], sdi_s};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) rx_done <= 1'b1;
            end
            if (sck_fall) begin
              if (bit_cnt == 3'd0) begin
                tx_shift <= reload_byte;
                sdo_int  <= reload_byte[7];
              end else begin
                tx_shift <= {tx_shift[6:0], 1'b0};
                sdo_int  <= tx_shift[6];
              end
            end
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

  // TX holding register: a CPU queue write beats a simultaneous reload, so the
  // reload sees the old byte and the new one stays pending for the next byte.
  always_ff @(posedge clk) begin
    if (!resetx) begin
      hold    <= 8'h00;
      pending <= 1'b0;
    end else if (queue_wr) begin
      hold    <= in[7:0];
      pending <= 1'b1;
    end else if (reload && pending) begin
      pending <= 1'b0;
    end
  end

  // RX status: a completed byte always wins over a clear in the same cycle,
  // and in that case the clear still cancels any overrun.
  always_ff @(posedge clk) begin
    if (!resetx) begin
      rx_empty <= 1'b1;
      overrun  <= 1'b0;
      rx_data  <= 8'h00;
    end else if (rx_done) begin
      rx_data  <= rx_shift;
      rx_empty <= 1'b0;
      if (clear_wr)       overrun <= 1'b0;
      else if (!rx_empty) overrun <= 1'b1;
    end else if (clear_wr) begin
      rx_empty <= 1'b1;
      overrun  <= 1'b0;
    end
  end

`ifdef SPI_RESPONDER_FRAMECNT_EN
  logic [4:0] frame_cnt;

  // Complete-byte count for the current or most recent frame.
  always_ff @(posedge clk) begin
    if (!resetx) begin
      frame_cnt <= 5'd0;
    end else if ((state == ST_IDLE) && cs_fall) begin
      frame_cnt <= 5'd0;
    end else if (rx_done && (frame_cnt != 5'd31)) begin
      frame_cnt <= frame_cnt + 5'd1;
    end
  end

  assign frame_field = frame_cnt;
`else
  assign frame_field = 5'd0;
`endif

  // Pad register: one extra stage so SDO and SDO_EN change together and
  // never glitch from the combinational edge logic.
  always_ff @(posedge clk) begin
    if (!resetx) begin
      SDO    <= 1'b1;
      SDO_EN <= 1'b0;
    end else begin
      SDO    <= sdo_int;
      SDO_EN <= sdo_en_int;
    end
  end

  assign out = {rx_empty, pending, overrun, frame_field, rx_data};

endmodule
